// File: rtl/not_32.sv
// -----------------------------------------------------------------------------
// not_32 -- bitwise inverter (one's complement) for the ALU datapath.
//
// The primary output `result` is pure continuous logic (~A). It has zero
// latency and never depends on clock, clear or en. A registered copy of the
// result plus two status flags and a one-cycle valid strobe are provided for
// pipelined consumers such as the Z register path and the condition logic.
//
// Parameters:
//   WIDTH     operand/result width in bits (default 32)
//
// Ports:
//   clock     in   1      rising-edge clock, used by the registered outputs only
//   clear     in   1      asynchronous active-high reset of the registered outputs
//   A         in   WIDTH  operand
//   en        in   1      load enable for result_q / zero_q / ones_q / valid_q
//   result    out  WIDTH  combinational ~A
//   result_q  out  WIDTH  registered ~A
//   zero_q    out  1      registered flag: ~A == 0 (A all ones)
//   ones_q    out  1      registered flag: ~A all ones (A == 0)
//   valid_q   out  1      high for exactly the cycle after a load with en=1
// -----------------------------------------------------------------------------
module not_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] A,
    input  logic             en,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q,
    output logic             ones_q,
    output logic             valid_q
);

    // Strictly bitwise: an X/Z on one operand bit only corrupts that result bit.
    assign result = ~A;

    // Flags are derived from the operand rather than from `result` so that the
    // reduction does not add an inverter stage in front of the flag registers.
    logic a_all_ones;
    logic a_all_zero;

    assign a_all_ones = &A;
    assign a_all_zero = ~|A;

    // Reset state describes "nothing loaded yet": result_q is 0, so zero_q is
    // 1 to stay consistent with it. clear has priority over a same-edge load.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            ones_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            // valid_q is a strobe: it tracks en every cycle rather than holding.
            valid_q <= en;
            if (en) begin
                result_q <= ~A;
                zero_q   <= a_all_ones;
                ones_q   <= a_all_zero;
            end
        end
    end

endmodule

// File: tb/tb_not_32.sv
// -----------------------------------------------------------------------------
// tb_not_32 -- self-checking bench for not_32.
//
// The reference model computes the one's complement arithmetically
// (all-ones minus A) and tracks the registered outputs as plain variables
// updated from the load rules. Inputs change on the falling clock edge and
// registered outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_not_32;

    localparam int          WIDTH    = 32;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    logic             clock = 1'b0;
    logic             clk_run = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ones_q;
    logic             valid_q;

    int pass_count = 0;
    int total_count = 0;

    // Reference model state for the registered path.
    logic [WIDTH-1:0] exp_q;
    logic             exp_z;
    logic             exp_o;
    logic             exp_v;

    not_32 #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .clear    (clear),
        .A        (A),
        .en       (en),
        .result   (result),
        .result_q (result_q),
        .zero_q   (zero_q),
        .ones_q   (ones_q),
        .valid_q  (valid_q)
    );

    // Clock stays idle until clk_run is set, so the combinational checks run
    // with no edges at all.
    always begin
        #5;
        if (clk_run) clock = ~clock;
    end

    // Reference one's complement: all ones minus the operand (no borrows occur).
    function automatic logic [WIDTH-1:0] ref_not(input logic [WIDTH-1:0] a);
        return ALL_ONES - a;
    endfunction

    task automatic test_reset();
        clear = 1'b0;
        #1;
        clear = 1'b1;
        #1;
        total_count++;
        if ({result_q, zero_q, ones_q, valid_q} !== {32'h0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_state: got q=%h z=%b o=%b v=%b, expected q=00000000 z=1 o=0 v=0",
                     result_q, zero_q, ones_q, valid_q);
        else pass_count++;
        #3;
        clear = 1'b0;
        #1;
        total_count++;
        if ({result_q, zero_q, ones_q, valid_q} !== {32'h0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_release_hold: got q=%h z=%b o=%b v=%b, expected q=00000000 z=1 o=0 v=0",
                     result_q, zero_q, ones_q, valid_q);
        else pass_count++;
    endtask

    task automatic test_comb_idle();
        logic [WIDTH-1:0] vec [4];
        vec[0] = 32'h0000_0000;
        vec[1] = 32'hFFFF_FFFF;
        vec[2] = 32'h0000_000F;
        vec[3] = 32'hAAAA_AAAA;
        A = vec[0];
        #1;
        total_count++;
        if (result !== 32'hFFFF_FFFF)
            $display("FAIL comb_zero_fast: got %h expected ffffffff", result);
        else pass_count++;
        for (int i = 0; i < 4; i++) begin
            A = vec[i];
            #10;
            total_count++;
            if (result !== ref_not(vec[i]))
                $display("FAIL comb_vec%0d: A=%h got %h expected %h",
                         i, vec[i], result, ref_not(vec[i]));
            else pass_count++;
        end
    endtask

    task automatic test_clear_pulse();
        logic [WIDTH-1:0] a_val;
        a_val = 32'h1234_5678 ^ $urandom();
        if (a_val == '0 || a_val == ALL_ONES) a_val = 32'h0F0F_0F0F;
        @(negedge clock);
        A  = a_val;
        en = 1'b1;
        @(posedge clock);
        #1;
        total_count++;
        if ({result_q, valid_q} !== {ref_not(a_val), 1'b1})
            $display("FAIL preload: got q=%h v=%b expected q=%h v=1",
                     result_q, valid_q, ref_not(a_val));
        else pass_count++;
        @(negedge clock);
        en = 1'b0;
        #2;
        clear = 1'b1;
        #1;
        total_count++;
        if ({result_q, zero_q, ones_q, valid_q} !== {32'h0, 1'b1, 1'b0, 1'b0})
            $display("FAIL clear_async: got q=%h z=%b o=%b v=%b, expected q=00000000 z=1 o=0 v=0",
                     result_q, zero_q, ones_q, valid_q);
        else pass_count++;
        total_count++;
        if (result !== ref_not(a_val))
            $display("FAIL clear_comb_unaffected: got %h expected %h", result, ref_not(a_val));
        else pass_count++;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_load_hold();
        logic [WIDTH-1:0] a_next;
        @(negedge clock);
        A  = '0;
        en = 1'b1;
        @(posedge clock);
        #1;
        total_count++;
        if ({result_q, zero_q, ones_q, valid_q} !== {32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1})
            $display("FAIL load_zero: got q=%h z=%b o=%b v=%b, expected q=ffffffff z=0 o=1 v=1",
                     result_q, zero_q, ones_q, valid_q);
        else pass_count++;
        a_next = $urandom();
        @(negedge clock);
        A  = a_next;
        en = 1'b0;
        @(posedge clock);
        #1;
        total_count++;
        if ({result_q, zero_q, ones_q, valid_q} !== {32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0})
            $display("FAIL hold_en0: got q=%h z=%b o=%b v=%b, expected q=ffffffff z=0 o=1 v=0",
                     result_q, zero_q, ones_q, valid_q);
        else pass_count++;
    endtask

    task automatic test_clear_wins();
        @(negedge clock);
        A     = ALL_ONES;
        en    = 1'b1;
        clear = 1'b1;
        @(posedge clock);
        #1;
        total_count++;
        if ({result_q, zero_q, ones_q, valid_q} !== {32'h0, 1'b1, 1'b0, 1'b0})
            $display("FAIL clear_beats_load: got q=%h z=%b o=%b v=%b, expected q=00000000 z=1 o=0 v=0",
                     result_q, zero_q, ones_q, valid_q);
        else pass_count++;
        @(negedge clock);
        clear = 1'b0;
        @(posedge clock);
        #1;
        total_count++;
        if ({result_q, zero_q, ones_q, valid_q} !== {32'h0, 1'b1, 1'b0, 1'b1})
            $display("FAIL first_load_after_clear: got q=%h z=%b o=%b v=%b, expected q=00000000 z=1 o=0 v=1",
                     result_q, zero_q, ones_q, valid_q);
        else pass_count++;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a_val;
        logic             en_val;
        int               comb_errs = 0;
        int               reg_errs = 0;
        // Registers hold the last load from test_clear_wins (A = all ones).
        exp_q = '0;
        exp_z = 1'b1;
        exp_o = 1'b0;
        exp_v = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(15))
                0:       a_val = '0;
                1:       a_val = ALL_ONES;
                default: a_val = $urandom();
            endcase
            en_val = ($urandom_range(2) != 0);
            @(negedge clock);
            A  = a_val;
            en = en_val;
            #1;
            total_count++;
            if (result !== ref_not(a_val) || (result ^ a_val) !== ALL_ONES) begin
                if (comb_errs < 10)
                    $display("FAIL rand_comb[%0d]: A=%h got %h expected %h", i, a_val, result, ref_not(a_val));
                comb_errs++;
            end else pass_count++;
            if (en_val) begin
                exp_q = ref_not(a_val);
                exp_z = (a_val == ALL_ONES);
                exp_o = (a_val == '0);
            end
            exp_v = en_val;
            @(posedge clock);
            #1;
            total_count++;
            if ({result_q, zero_q, ones_q, valid_q} !== {exp_q, exp_z, exp_o, exp_v}) begin
                if (reg_errs < 10)
                    $display("FAIL rand_reg[%0d]: got q=%h z=%b o=%b v=%b, expected q=%h z=%b o=%b v=%b",
                             i, result_q, zero_q, ones_q, valid_q, exp_q, exp_z, exp_o, exp_v);
                reg_errs++;
            end else pass_count++;
        end
    endtask

    initial begin
        test_reset();
        test_comb_idle();
        clk_run = 1'b1;
        test_clear_pulse();
        test_load_hold();
        test_clear_wins();
        test_random();
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

    // Guard against a stalled run; the normal flow ends far earlier.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
